// File: rtl/mist1032isa_memory_master_pkg.sv
// Shared types and helpers for the memory master: order encodings, info-entry
// layout, write-lane shift, read-result extraction and the misalignment test.
package mist1032isa_memory_master_pkg;

  localparam logic [1:0] ORDER_BYTE = 2'b00;
  localparam logic [1:0] ORDER_HALF = 2'b01;
  localparam logic [1:0] ORDER_WORD = 2'b10;
  localparam logic [1:0] ORDER_NONE = 2'b11;

  localparam int INFO_W = 5;

  typedef struct packed {
    logic [2:0] addr;
    logic [1:0] order;
  } info_t;

  function automatic logic [4:0] lane_shift(input logic [1:0] byte_ofs);
    return {byte_ofs, 3'b000};
  endfunction

  // Select the addressed word of the doubleword, right-justify it, then mask by order.
  function automatic logic [31:0] extract_read(input logic [63:0] beat,
                                               input logic [2:0]  addr,
                                               input logic [1:0]  order);
    logic [31:0] word;
    word = addr[2] ? beat[63:32] : beat[31:0];
    word = word >> lane_shift(addr[1:0]);
    case (order)
      ORDER_BYTE: return {24'h0, word[7:0]};
      ORDER_HALF: return {16'h0, word[15:0]};
      default:    return word;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] order, input logic [1:0] byte_ofs);
    return ((order == ORDER_WORD) && (byte_ofs != 2'b00)) ||
           ((order == ORDER_HALF) && (byte_ofs == 2'b11)) ||
           (order == ORDER_NONE);
  endfunction

endpackage

// File: rtl/mist1032isa_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; head is visible
// on oRD_DATA while not empty. DEPTH must equal 2**D_N.
module mist1032isa_sync_fifo #(
  parameter int N     = 5,
  parameter int DEPTH = 4,
  parameter int D_N   = 2
) (
  input  logic         iCLOCK,
  input  logic         iRESET_SYNC,
  input  logic         iWR_EN,
  input  logic [N-1:0] iWR_DATA,
  output logic         oFULL,
  input  logic         iRD_EN,
  output logic [N-1:0] oRD_DATA,
  output logic         oEMPTY
);

  logic [N-1:0] mem [DEPTH];
  logic [D_N-1:0] wr_ptr;
  logic [D_N-1:0] rd_ptr;
  logic [D_N:0]   count;
  logic           do_wr;
  logic           do_rd;

  assign oFULL    = (count == (D_N+1)'(DEPTH));
  assign oEMPTY   = (count == '0);
  assign oRD_DATA = mem[rd_ptr];
  assign do_wr    = iWR_EN && !oFULL;
  assign do_rd    = iRD_EN && !oEMPTY;

  always_ff @(posedge iCLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (iRESET_SYNC) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count gate every read of it.
  always_ff @(posedge iCLOCK) begin
    if (do_wr) mem[wr_ptr] <= iWR_DATA;
  end

endmodule

// File: rtl/mist1032isa_memory_master.sv
// Requester end of the 64-bit-response memory port: one-entry command buffer,
// read-info FIFO and registered right-justified read result.
// Optional: MIST1032ISA_MEMORY_MASTER_ALIGN_CHECK_EN discards misaligned commands and adds oCMD_ERROR.
module mist1032isa_memory_master
  import mist1032isa_memory_master_pkg::*;
#(
  parameter int P_INFO_DEPTH   = 4,
  parameter int P_INFO_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iCMD_REQ,
  output logic        oCMD_BUSY,
`ifdef MIST1032ISA_MEMORY_MASTER_ALIGN_CHECK_EN
  output logic        oCMD_ERROR,
`endif
  input  logic        iCMD_RW,
  input  logic [1:0]  iCMD_ORDER,
  input  logic [25:0] iCMD_ADDR,
  input  logic [31:0] iCMD_DATA,
  output logic        oRD_VALID,
  input  logic        iRD_BUSY,
  output logic [31:0] oRD_DATA,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic        oMEMORY_RW,
  output logic [25:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_LOCK,
  input  logic [63:0] iMEMORY_DATA
);

  logic        buf_valid;
  logic        buf_rw;
  logic [1:0]  buf_order;
  logic [25:0] buf_addr;
  logic [31:0] buf_data;
  logic        accept;
  logic        issue;
  logic        discard;
  logic        info_push;
  logic        info_pop;
  logic        info_full;
  logic        info_empty;
  info_t       info_head;
  logic [31:0] rd_data;
  logic        rd_valid;

`ifdef MIST1032ISA_MEMORY_MASTER_ALIGN_CHECK_EN
  logic buf_mis;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC)  buf_mis <= 1'b0;
    else if (accept)  buf_mis <= misaligned(iCMD_ORDER, iCMD_ADDR[1:0]);
  end

  assign discard    = buf_valid && buf_mis;
  assign oCMD_ERROR = discard;
`else
  assign discard = 1'b0;
`endif

  // A full info FIFO stalls a read even when a response pops in the same cycle.
  assign issue     = buf_valid && !discard && !iMEMORY_LOCK && (buf_rw || !info_full);
  assign oCMD_BUSY = buf_valid && !issue && !discard;
  assign accept    = iCMD_REQ && !oCMD_BUSY;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      buf_valid <= 1'b0;
      buf_rw    <= 1'b0;
      buf_order <= 2'b00;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (accept) begin
      buf_valid <= 1'b1;
      buf_rw    <= iCMD_RW;
      buf_order <= iCMD_ORDER;
      buf_addr  <= iCMD_ADDR;
      buf_data  <= iCMD_DATA << lane_shift(iCMD_ADDR[1:0]);
    end else if (issue || discard) begin
      buf_valid <= 1'b0;
    end
  end

  assign oMEMORY_REQ   = buf_valid && !discard;
  assign oMEMORY_RW    = buf_rw;
  assign oMEMORY_ORDER = buf_order;
  assign oMEMORY_ADDR  = buf_addr;
  assign oMEMORY_DATA  = buf_data;

  assign info_push = issue && !buf_rw;
  // A response with nothing outstanding is dropped without touching the FIFO.
  assign info_pop  = iMEMORY_VALID && !info_empty;

  mist1032isa_sync_fifo #(
    .N     (INFO_W),
    .DEPTH (P_INFO_DEPTH),
    .D_N   (P_INFO_DEPTH_N)
  ) u_info_fifo (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iWR_EN      (info_push),
    .iWR_DATA    ({buf_addr[2:0], buf_order}),
    .oFULL       (info_full),
    .iRD_EN      (info_pop),
    .oRD_DATA    (info_head),
    .oEMPTY      (info_empty)
  );

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (info_pop) begin
      rd_valid <= 1'b1;
      rd_data  <= extract_read(iMEMORY_DATA, info_head.addr, info_head.order);
    end else if (rd_valid && !iRD_BUSY) begin
      rd_valid <= 1'b0;
    end
  end

  assign oRD_VALID    = rd_valid;
  assign oRD_DATA     = rd_data;
  assign oMEMORY_LOCK = rd_valid && iRD_BUSY;

endmodule

// File: tb/tb_mist1032isa_memory_master.sv
// Scoreboard bench for mist1032isa_memory_master: directed commands and
// responses push expectations; a negedge monitor pops and compares.
module tb_mist1032isa_memory_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_req, cmd_busy, cmd_rw;
  logic [1:0]  cmd_order;
  logic [25:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rd_valid, rd_busy;
  logic [31:0] rd_data;
  logic        mem_req, mem_lock_in, mem_rw, mem_valid, mem_lock_out;
  logic [1:0]  mem_order;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [63:0] mem_rdata;
`ifdef MIST1032ISA_MEMORY_MASTER_ALIGN_CHECK_EN
  logic        cmd_error;
`endif

  always #5 clk = ~clk;

  mist1032isa_memory_master #(.P_INFO_DEPTH(4), .P_INFO_DEPTH_N(2)) dut (
    .iCLOCK        (clk),
    .iRESET_SYNC   (rst),
    .iCMD_REQ      (cmd_req),
    .oCMD_BUSY     (cmd_busy),
`ifdef MIST1032ISA_MEMORY_MASTER_ALIGN_CHECK_EN
    .oCMD_ERROR    (cmd_error),
`endif
    .iCMD_RW       (cmd_rw),
    .iCMD_ORDER    (cmd_order),
    .iCMD_ADDR     (cmd_addr),
    .iCMD_DATA     (cmd_data),
    .oRD_VALID     (rd_valid),
    .iRD_BUSY      (rd_busy),
    .oRD_DATA      (rd_data),
    .oMEMORY_REQ   (mem_req),
    .iMEMORY_LOCK  (mem_lock_in),
    .oMEMORY_ORDER (mem_order),
    .oMEMORY_RW    (mem_rw),
    .oMEMORY_ADDR  (mem_addr),
    .oMEMORY_DATA  (mem_wdata),
    .iMEMORY_VALID (mem_valid),
    .oMEMORY_LOCK  (mem_lock_out),
    .iMEMORY_DATA  (mem_rdata)
  );

  typedef struct packed {
    logic        rw;
    logic [1:0]  order;
    logic [25:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  int          checks = 0;
  int          errors = 0;
  int          outstanding = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic rw, input logic [1:0] order,
                                  input logic [25:0] addr, input logic [31:0] data);
    req_t r;
    r.rw = rw; r.order = order; r.addr = addr; r.data = data;
    return r;
  endfunction

  // Monitor: a request transfers when presented, not locked, and (for reads)
  // fewer than 4 reads are outstanding at the start of the cycle.
  always @(negedge clk) begin
    req_t e;
    logic push, pop;
    push = 1'b0;
    pop  = 1'b0;
    if (rst) begin
      outstanding = 0;
    end else begin
      if (mem_req && !mem_lock_in && (mem_rw || outstanding < 4)) begin
        push = !mem_rw;
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got addr %h rw %b expected no request", mem_addr, mem_rw);
        end else begin
          e = exp_req.pop_front();
          check("req_rw",    64'(mem_rw),    64'(e.rw));
          check("req_order", 64'(mem_order), 64'(e.order));
          check("req_addr",  64'(mem_addr),  64'(e.addr));
          if (e.rw) check("req_wdata", 64'(mem_wdata), 64'(e.data));
        end
      end
      if (mem_valid && outstanding > 0) pop = 1'b1;
      outstanding = outstanding + int'(push) - int'(pop);
      if (rd_valid && !rd_busy) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got %h expected no result", rd_data);
        end else begin
          check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic rw, input logic [1:0] order,
                      input logic [25:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    cmd_req = 1'b1; cmd_rw = rw; cmd_order = order; cmd_addr = addr; cmd_data = data;
    @(negedge clk);
    while (cmd_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: got busy for %0d cycles expected accept", n);
    end
    @(posedge clk); #1;
    cmd_req = 1'b0;
  endtask

  task automatic resp(input logic [63:0] d);
    mem_valid = 1'b1;
    mem_rdata = d;
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   64'(cmd_busy),     64'd0);
    check({tag, "_rdv"},    64'(rd_valid),     64'd0);
    check({tag, "_rdd"},    64'(rd_data),      64'd0);
    check({tag, "_req"},    64'(mem_req),      64'd0);
    check({tag, "_order"},  64'(mem_order),    64'd0);
    check({tag, "_rw"},     64'(mem_rw),       64'd0);
    check({tag, "_addr"},   64'(mem_addr),     64'd0);
    check({tag, "_wdata"},  64'(mem_wdata),    64'd0);
    check({tag, "_mlock"},  64'(mem_lock_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_req = 1'b0; cmd_rw = 1'b0; cmd_order = 2'b00; cmd_addr = '0; cmd_data = '0;
    rd_busy = 1'b0; mem_lock_in = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check_idle("reset");

    // Word read at 0x4: high word of the beat.
    exp_req.push_back(mk_req(1'b0, 2'b10, 26'h4, 32'h0));
    send(1'b0, 2'b10, 26'h4, 32'h0);
    check("rd_req_latency", 64'(mem_req), 64'd1);
    cycles(1);
    exp_rd.push_back(32'h11223344);
    resp(64'h1122334455667788);
    check("rd_resp_latency", 64'(rd_valid), 64'd1);
    cycles(2);

    // Byte read at 0x7: top byte of the high word.
    exp_req.push_back(mk_req(1'b0, 2'b00, 26'h7, 32'h0));
    send(1'b0, 2'b00, 26'h7, 32'h0);
    cycles(1);
    exp_rd.push_back(32'h0000005A);
    resp(64'h5A00000000000000);
    cycles(2);

    // Byte write at offset 1 held under lock, with a second command waiting.
    mem_lock_in = 1'b1;
    exp_req.push_back(mk_req(1'b1, 2'b00, 26'h1, 32'h0000AB00));
    send(1'b1, 2'b00, 26'h1, 32'h000000AB);
    exp_req.push_back(mk_req(1'b1, 2'b10, 26'h8, 32'h12345678));
    cmd_req = 1'b1; cmd_rw = 1'b1; cmd_order = 2'b10; cmd_addr = 26'h8; cmd_data = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_req",   64'(mem_req),   64'd1);
      check("hold_wdata", 64'(mem_wdata), 64'h0000AB00);
      check("hold_addr",  64'(mem_addr),  64'h1);
      check("hold_order", 64'(mem_order), 64'd0);
      check("hold_busy",  64'(cmd_busy),  64'd1);
      @(posedge clk); #1;
    end
    mem_lock_in = 1'b0;
    @(negedge clk);
    check("b2b_busy", 64'(cmd_busy), 64'd0);
    @(posedge clk); #1;
    cmd_req = 1'b0;
    cycles(2);

    // Outstanding limit: four reads issue, the fifth waits for a pop.
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(mk_req(1'b0, 2'b10, 26'h10 + 26'(4*i), 32'h0));
      send(1'b0, 2'b10, 26'h10 + 26'(4*i), 32'h0);
    end
    send(1'b0, 2'b10, 26'h20, 32'h0);
    cycles(3);
    check("full_req_held", 64'(mem_req),  64'd1);
    check("full_busy",     64'(cmd_busy), 64'd1);
    exp_req.push_back(mk_req(1'b0, 2'b10, 26'h20, 32'h0));
    exp_rd.push_back(32'h89ABCDEF);
    resp(64'h0123456789ABCDEF);
    exp_rd.push_back(32'hDEADBEEF);
    resp(64'hDEADBEEF00000000);
    exp_rd.push_back(32'h55AA55AA);
    resp(64'h0000000055AA55AA);
    exp_rd.push_back(32'hCAFEF00D);
    resp(64'hCAFEF00D11111111);
    exp_rd.push_back(32'hA5A5A5A5);
    resp(64'h00000000A5A5A5A5);
    cycles(3);

    // Halfword read at offset 2 under result back-pressure.
    exp_req.push_back(mk_req(1'b0, 2'b01, 26'h2, 32'h0));
    send(1'b0, 2'b01, 26'h2, 32'h0);
    cycles(1);
    rd_busy = 1'b1;
    exp_rd.push_back(32'h0000CAFE);
    resp(64'h00000000CAFE1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rd_valid),     64'd1);
      check("bp_lock",  64'(mem_lock_out), 64'd1);
      check("bp_data",  64'(rd_data),      64'h0000CAFE);
      @(posedge clk); #1;
    end
    rd_busy = 1'b0;
    @(negedge clk);
    check("bp_release_lock", 64'(mem_lock_out), 64'd0);
    @(posedge clk); #1;
    check("bp_drained", 64'(rd_valid), 64'd0);

    // Reset with two reads outstanding; late responses must be dropped.
    exp_req.push_back(mk_req(1'b0, 2'b10, 26'h30, 32'h0));
    send(1'b0, 2'b10, 26'h30, 32'h0);
    exp_req.push_back(mk_req(1'b0, 2'b10, 26'h34, 32'h0));
    send(1'b0, 2'b10, 26'h34, 32'h0);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    resp(64'h1111111122222222);
    resp(64'h3333333344444444);
    cycles(2);
    check_idle("post_reset");

`ifdef MIST1032ISA_MEMORY_MASTER_ALIGN_CHECK_EN
    // Misaligned word read is accepted, flagged once and discarded.
    send(1'b0, 2'b10, 26'h2, 32'h0);
    check("mis_error", 64'(cmd_error), 64'd1);
    check("mis_req",   64'(mem_req),   64'd0);
    cycles(1);
    check("mis_error_pulse", 64'(cmd_error), 64'd0);
    check("mis_req_after",   64'(mem_req),   64'd0);
    resp(64'hFFFFFFFFFFFFFFFF);
    cycles(3);
`endif

    cycles(3);
    check("req_queue_drained", 64'(exp_req.size()), 64'd0);
    check("rd_queue_drained",  64'(exp_rd.size()),  64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
